exu_cal_arb: RTL and testbench
==============================

Name: exu_cal_arb

Overview:
- Sequencer and arbiter that shares the single `exu_cal` integer calculation unit between NREQ requesters in the execute stage (main ALU path, branch-compare path, AGU, ...).
- Grants one requester per cycle and drives the calc unit's val/opb interface.
- Registers the 32-bit result into a one-entry response buffer.
- Holds that result until the winning requester accepts it. Back-to-back issue is supported when the buffer drains in the same cycle.

Parameters:
- NREQ, 2, number of requesters (2..4).
- OPB_W, `CIRNO_CAL_OPB_SIZE`, width of one operand/opcode bundle.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  pipeline flush; discards the held result and blocks grant this cycle.
- req_val  input  NREQ  per-requester request valid.
- req_rdy  output  NREQ  per-requester grant/accept (one-hot or zero).
- req_opb  input  NREQ*OPB_W  packed bundles; requester i occupies bits [i*OPB_W +: OPB_W].
- rsp_val  output  NREQ  one-hot result valid, addressed to the granted requester.
- rsp_rdy  input  NREQ  per-requester result accept.
- rsp_res  output  32  held result.
- hs_ex4cal_val  output  1  issue strobe to calc unit.
- hs_cal4ex_rdy  input  1  calc unit ready.
- cal_opb  output  OPB_W  bundle to calc unit; all-zero when not issuing.
- cal_res  input  32  combinational calc result.

Behaviour:
- Reset (async, rst=1): state=IDLE, rsp_val=0, rsp_res=0, held id=0, RR pointer=0.
- While rst is high, combinational outputs reduce to: req_rdy=0, hs_ex4cal_val=0, cal_opb=0.
- State machine states:
  - IDLE: buffer empty.
  - HOLD: buffer holds result for id H.
- can_issue = hs_cal4ex_rdy & ~flush & (state==IDLE | (state==HOLD & rsp_rdy[H])).
- Grant:
  - If can_issue and any req_val, exactly one req_rdy bit is set: the first set req_val bit searching upward from the RR pointer, wrapping modulo NREQ.
  - Otherwise req_rdy=0.
  - req_rdy may depend combinationally on req_val. Requesters must not make req_val depend on req_rdy.
- Issue cycle (req_val[g]&req_rdy[g]):
  - hs_ex4cal_val=1 and cal_opb=req_opb slice g, combinationally in the same cycle.
  - At the clock edge: rsp_res<=cal_res, H<=g, state<=HOLD, RR pointer<=(g+1) mod NREQ.
- Latency: a request accepted in cycle N produces rsp_val[g]=1 in cycle N+1.
- Throughput: 1 op/cycle when the consumer accepts every cycle.
- HOLD without rsp_rdy[H]: rsp_res and H stay stable and no grant is made.
- HOLD with rsp_rdy[H]:
  - With a new grant: the state stays HOLD with the new result.
  - Without a new grant: the state goes to IDLE.
- rsp_rdy bits other than H are ignored.
- flush=1: the state goes to IDLE at the edge, rsp_val drops the next cycle, and there is no grant that cycle. Flush overrides any simultaneous rsp_rdy or req_val.
- hs_cal4ex_rdy=0: no grant; the held result is unaffected and is still drained by rsp_rdy.
- No requests pending: hs_ex4cal_val=0 and cal_opb=0.
- The RR pointer is unchanged in cycles without a grant.

Optional Feature:
- CIRNO_CAL_ARB_RR_EN defined: round-robin arbitration as above.
- CIRNO_CAL_ARB_RR_EN undefined: fixed priority, lowest index wins. The RR pointer register is removed and the pointer is treated as constant 0.

Test Plan:
- Reset, then req_val=01 with req 0 ADD 5+3, rsp_rdy=11 -> req_rdy=01 and hs_ex4cal_val=1 in cycle N; rsp_val=01, rsp_res=8 in N+1.
- req_val=11 held for 4 cycles (RR_EN), rsp_rdy=11, req 0 SUB 10-4, req 1 XOR 0xF0^0x0F -> grants 0,1,0,1; rsp_res alternates 6 and 0xFF.
- Same stimulus with RR_EN undefined -> grants 0,0,0,0.
- Issue req 0 ADD 1+1, then hold rsp_rdy=00 for 3 cycles with req_val=11 -> rsp_val=01 and rsp_res=2 stable, req_rdy=00, hs_ex4cal_val=0. Raise rsp_rdy[0] -> req 1 is granted in that same cycle.
- HOLD with rsp_val=10, assert flush together with req_val=01 -> no grant that cycle; rsp_val=00 next cycle; req 0 is granted the cycle after.
- Assert rst asynchronously mid-HOLD (between edges) -> rsp_val=0 and rsp_res=0 immediately. After release, req_val=11 grants req 0 (pointer reset).

Source files
------------

// File: rtl/exu_cal_arb.sv
// Arbiter/sequencer sharing one exu_cal unit among NREQ execute-stage requesters,
// with a one-entry result buffer. Define CIRNO_CAL_ARB_RR_EN for round-robin, else fixed priority.
`ifndef CIRNO_CAL_OPB_SIZE
`define CIRNO_CAL_OPB_SIZE 68
`endif

module exu_cal_arb #(
  parameter int NREQ  = 2,
  parameter int OPB_W = `CIRNO_CAL_OPB_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NREQ-1:0]         req_val,
  output logic [NREQ-1:0]         req_rdy,
  input  logic [NREQ*OPB_W-1:0]   req_opb,
  output logic [NREQ-1:0]         rsp_val,
  input  logic [NREQ-1:0]         rsp_rdy,
  output logic [31:0]             rsp_res,
  output logic                    hs_ex4cal_val,
  input  logic                    hs_cal4ex_rdy,
  output logic [OPB_W-1:0]        cal_opb,
  input  logic [31:0]             cal_res,
  output logic                    dbg_state_o
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Valid/ready: a requester's op is issued in the cycle req_val[i] & req_rdy[i];
  // its result is consumed in the cycle rsp_val[i] & rsp_rdy[i].
  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   hid_q, hid_d;
  logic [31:0]      res_q, res_d;
  logic [IDW-1:0]   ptr;
  logic             drain;
  logic             can_issue;
  logic             issue;
  logic [NREQ-1:0]  gnt_oh;
  logic [IDW-1:0]   gnt_id;
  logic             found;
  logic [IDW:0]     sum;
  logic [IDW-1:0]   idx;

`ifdef CIRNO_CAL_ARB_RR_EN
  logic [IDW-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (issue) ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  assign drain     = (state_q == S_HOLD) & rsp_rdy[hid_q];
  // Reset is folded in so the combinational outputs are quiet while rst is held.
  assign can_issue = ~rst & hs_cal4ex_rdy & ~flush & ((state_q == S_IDLE) | drain);

  // First pending requester at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    gnt_oh = '0;
    gnt_id = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (!found && can_issue && req_val[idx]) begin
        found       = 1'b1;
        gnt_oh[idx] = 1'b1;
        gnt_id      = idx;
      end
    end
  end

  assign issue         = found;
  assign req_rdy       = gnt_oh;
  assign hs_ex4cal_val = issue;

  always_comb begin
    cal_opb = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) cal_opb = req_opb[i*OPB_W +: OPB_W];
    end
  end

  always_comb begin
    rsp_val = '0;
    if (state_q == S_HOLD) rsp_val[hid_q] = 1'b1;
  end

  assign rsp_res     = res_q;
  assign dbg_state_o = state_q;

  // Flush wins over both a new issue and a drain of the held result.
  always_comb begin
    state_d = state_q;
    hid_d   = hid_q;
    res_d   = res_q;
    if (flush) begin
      state_d = S_IDLE;
    end else if (issue) begin
      state_d = S_HOLD;
      hid_d   = gnt_id;
      res_d   = cal_res;
    end else if (drain) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hid_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      hid_q   <= hid_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_exu_cal_arb.sv
// Directed bench for exu_cal_arb: a reference model of the arbitration rules checks
// every cycle, while the directed sequences pin hand-computed values.
module tb_exu_cal_arb;

  localparam int NREQ  = 2;
  localparam int OPB_W = 68;
`ifdef CIRNO_CAL_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;

  logic                  clk;
  logic                  rst;
  logic                  flush;
  logic [NREQ-1:0]       req_val;
  logic [NREQ-1:0]       req_rdy;
  logic [NREQ*OPB_W-1:0] req_opb;
  logic [NREQ-1:0]       rsp_val;
  logic [NREQ-1:0]       rsp_rdy;
  logic [31:0]           rsp_res;
  logic                  hs_ex4cal_val;
  logic                  hs_cal4ex_rdy;
  logic [OPB_W-1:0]      cal_opb;
  logic [31:0]           cal_res;
  logic                  dbg_state_o;

  int  checks = 0;
  int  errors = 0;
  bit  done   = 1'b0;

  logic [31:0] exp_q[$];
  int          id_q[$];
  int          m_ptr = 0;

  exu_cal_arb #(.NREQ(NREQ), .OPB_W(OPB_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .req_val       (req_val),
    .req_rdy       (req_rdy),
    .req_opb       (req_opb),
    .rsp_val       (rsp_val),
    .rsp_rdy       (rsp_rdy),
    .rsp_res       (rsp_res),
    .hs_ex4cal_val (hs_ex4cal_val),
    .hs_cal4ex_rdy (hs_cal4ex_rdy),
    .cal_opb       (cal_opb),
    .cal_res       (cal_res),
    .dbg_state_o   (dbg_state_o)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bundle layout: {op[3:0], a[31:0], b[31:0]}
  function automatic logic [OPB_W-1:0] mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    return {op, a, b};
  endfunction

  function automatic logic [31:0] calc(input logic [OPB_W-1:0] opb);
    logic [31:0] a, b;
    a = opb[63:32];
    b = opb[31:0];
    case (opb[67:64])
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  assign cal_res = calc(cal_opb);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard / reference model: evaluated once per cycle with inputs settled.
  task automatic model_step();
    logic [NREQ-1:0]  e_rdy, e_val;
    logic [OPB_W-1:0] e_opb;
    int g, hid, idx;
    bit hold, drain, ci;
    if (rst) begin
      chk("m_rst_req_rdy", req_rdy, 0);
      chk("m_rst_cal_val", hs_ex4cal_val, 0);
      chk("m_rst_cal_opb", cal_opb, 0);
      chk("m_rst_rsp_val", rsp_val, 0);
      chk("m_rst_rsp_res", rsp_res, 0);
      exp_q.delete();
      id_q.delete();
      m_ptr = 0;
      return;
    end
    hold  = (exp_q.size() != 0);
    hid   = hold ? id_q[0] : 0;
    e_val = hold ? NREQ'(1 << hid) : '0;
    drain = hold && rsp_rdy[hid];
    ci    = hs_cal4ex_rdy && !flush && (!hold || drain);
    g = -1;
    if (ci) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && req_val[idx]) g = idx;
      end
    end
    e_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
    e_opb = (g >= 0) ? req_opb[g*OPB_W +: OPB_W] : '0;
    chk("m_req_rdy", req_rdy, e_rdy);
    chk("m_cal_val", hs_ex4cal_val, (g >= 0));
    chk("m_cal_opb", cal_opb, e_opb);
    chk("m_rsp_val", rsp_val, e_val);
    chk("m_state", dbg_state_o, hold);
    if (hold) chk("m_rsp_res", rsp_res, exp_q[0]);
    if (flush) begin
      exp_q.delete();
      id_q.delete();
    end else if (g >= 0) begin
      if (hold) begin
        void'(exp_q.pop_front());
        void'(id_q.pop_front());
      end
      exp_q.push_back(calc(e_opb));
      id_q.push_back(g);
      m_ptr = RR ? (g + 1) % NREQ : 0;
    end else if (drain) begin
      void'(exp_q.pop_front());
      void'(id_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!done) model_step();
  end

  // Driver tasks
  task automatic drive(input logic [1:0] rv, input logic [1:0] rr, input logic fl, input logic hr);
    @(negedge clk);
    req_val       = rv;
    rsp_rdy       = rr;
    flush         = fl;
    hs_cal4ex_rdy = hr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_val = '0;
    rsp_rdy = '0;
    flush   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [1:0]  eg[4];
    logic [31:0] er[4];

    rst = 1'b1;
    flush = 1'b0;
    req_val = 2'b01;
    rsp_rdy = 2'b11;
    hs_cal4ex_rdy = 1'b1;
    req_opb = {mk(OP_ADD, 32'd9, 32'd9), mk(OP_ADD, 32'd5, 32'd3)};

    // Reset state with a pending request
    @(posedge clk);
    #1;
    chk("rst_req_rdy", req_rdy, 2'b00);
    chk("rst_cal_val", hs_ex4cal_val, 1'b0);
    chk("rst_cal_opb", cal_opb, 0);
    chk("rst_rsp_val", rsp_val, 2'b00);
    chk("rst_rsp_res", rsp_res, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_val = 2'b00;

    // Single ADD 5+3, one-cycle latency
    drive(2'b01, 2'b11, 1'b0, 1'b1);
    chk("add_req_rdy", req_rdy, 2'b01);
    chk("add_cal_val", hs_ex4cal_val, 1'b1);
    drive(2'b00, 2'b11, 1'b0, 1'b1);
    chk("add_rsp_val", rsp_val, 2'b01);
    chk("add_rsp_res", rsp_res, 32'd8);
    chk("idle_cal_opb", cal_opb, 0);

    // Both requesting for four cycles with a consumer that always accepts
    do_reset();
    req_opb = {mk(OP_XOR, 32'hF0, 32'h0F), mk(OP_SUB, 32'd10, 32'd4)};
    eg[0] = 2'b01;                 er[0] = 32'd6;
    eg[1] = RR ? 2'b10 : 2'b01;    er[1] = RR ? 32'hFF : 32'd6;
    eg[2] = 2'b01;                 er[2] = 32'd6;
    eg[3] = RR ? 2'b10 : 2'b01;    er[3] = RR ? 32'hFF : 32'd6;
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 2'b11, 1'b0, 1'b1);
      chk($sformatf("arb_grant%0d", i), req_rdy, eg[i]);
      if (i > 0) chk($sformatf("arb_res%0d", i - 1), rsp_res, er[i-1]);
    end
    drive(2'b00, 2'b11, 1'b0, 1'b1);
    chk("arb_res3", rsp_res, er[3]);

    // Back-pressure: held result stays put and blocks grants
    req_opb = {mk(OP_XOR, 32'hF0, 32'h0F), mk(OP_ADD, 32'd1, 32'd1)};
    drive(2'b01, 2'b11, 1'b0, 1'b1);
    chk("bp_issue", req_rdy, 2'b01);
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 2'b00, 1'b0, 1'b1);
      chk($sformatf("bp_rsp_val%0d", i), rsp_val, 2'b01);
      chk($sformatf("bp_rsp_res%0d", i), rsp_res, 32'd2);
      chk($sformatf("bp_req_rdy%0d", i), req_rdy, 2'b00);
      chk($sformatf("bp_cal_val%0d", i), hs_ex4cal_val, 1'b0);
    end
    drive(2'b11, 2'b01, 1'b0, 1'b1);
    chk("bp_release_grant", req_rdy, RR ? 2'b10 : 2'b01);

    // Flush while holding requester 1's result
    drive(2'b10, 2'b11, 1'b0, 1'b1);
    chk("fl_setup_grant", req_rdy, 2'b10);
    drive(2'b01, 2'b00, 1'b1, 1'b1);
    chk("fl_rsp_val", rsp_val, 2'b10);
    chk("fl_req_rdy", req_rdy, 2'b00);
    chk("fl_cal_val", hs_ex4cal_val, 1'b0);
    drive(2'b01, 2'b00, 1'b0, 1'b1);
    chk("fl_after_rsp_val", rsp_val, 2'b00);
    chk("fl_after_grant", req_rdy, 2'b01);

    // Calc unit not ready: no grant, but the held result still drains
    drive(2'b11, 2'b11, 1'b0, 1'b0);
    chk("nr_req_rdy", req_rdy, 2'b00);
    chk("nr_rsp_val", rsp_val, 2'b01);
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    chk("nr_drained", rsp_val, 2'b00);

    // Asynchronous reset between edges while holding
    drive(2'b01, 2'b00, 1'b0, 1'b1);
    chk("ar_issue", req_rdy, 2'b01);
    @(posedge clk);
    #1;
    chk("ar_hold_val", rsp_val, 2'b01);
    chk("ar_hold_res", rsp_res, 32'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_rsp_val", rsp_val, 2'b00);
    chk("ar_rsp_res", rsp_res, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_val = 2'b11;
    rsp_rdy = 2'b11;
    #1;
    chk("ar_ptr_reset_grant", req_rdy, 2'b01);
    drive(2'b00, 2'b11, 1'b0, 1'b1);
    chk("ar_res", rsp_res, 32'd2);
    drive(2'b00, 2'b11, 1'b0, 1'b1);

    @(negedge clk);
    #3;
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
